alu_result_collector: RTL and testbench

Downstream stage of the 16-bit ALU. Each cycle it samples the ALU's four registered result buses and their unit flags, selects the active unit's result, and tags it with a class code. It buffers tagged results in a small FIFO and presents them on a valid/ready stream to the consumer, so consumer back-pressure never stalls the ALU.

---
 rtl/alu_res_pkg.sv | 17 +
 rtl/alu_res_fifo.sv | 68 ++++++
 rtl/alu_result_collector.sv | 117 +++++++++++
 tb/tb_alu_result_collector.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_res_pkg.sv
// Shared definitions for the ALU result collector: class codes, entry sizing and
// drop-counter width.
package alu_res_pkg;

    localparam logic [1:0] CLS_ARITH = 2'b00;
    localparam logic [1:0] CLS_LOGIC = 2'b01;
    localparam logic [1:0] CLS_CMP   = 2'b10;
    localparam logic [1:0] CLS_SHIFT = 2'b11;

    localparam int DROP_CNT_W = 8;

    // A stored entry holds {2W data, 2-bit class, carry}.
    function automatic int entry_width(input int op_width);
        return 2 * op_width + 3;
    endfunction

endpackage

// File: rtl/alu_res_fifo.sv
// Generic synchronous FIFO with registered full/empty flags and a head output
// that reads as zero while empty.
module alu_res_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             full_q;
    logic             empty_q;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is accepted only when a pop frees the head slot.
    assign do_pop  = pop_i && !empty_q;
    assign do_push = push_i && (!full_q || do_pop);

    always_comb begin
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    assign data_o  = empty_q ? '0 : mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/alu_result_collector.sv
// Collects the ALU's per-unit results, tags them by class and buffers them onto a
// valid/ready stream. Define ALU_RES_DROP_CNT_EN to add the DROP_CNT counter port.
module alu_result_collector
    import alu_res_pkg::*;
#(
    parameter int OP_DATA_WIDTH = 16,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [2*OP_DATA_WIDTH-1:0] Arith_OUT,
    input  logic                       Carry_OUT,
    input  logic                       Arith_Flag,
    input  logic [OP_DATA_WIDTH-1:0]   Logic_OUT,
    input  logic                       Logic_Flag,
    input  logic [2:0]                 CMP_OUT,
    input  logic                       CMP_Flag,
    input  logic [OP_DATA_WIDTH-1:0]   Shift_OUT,
    input  logic                       Shift_Flag,
    output logic [2*OP_DATA_WIDTH-1:0] RES_DATA,
    output logic [1:0]                 RES_CLASS,
    output logic                       RES_CARRY,
    output logic                       RES_VALID,
    input  logic                       RES_READY,
    output logic                       FIFO_FULL,
    output logic                       OVERFLOW
`ifdef ALU_RES_DROP_CNT_EN
   ,output logic [DROP_CNT_W-1:0]      DROP_CNT
`endif
);

    localparam int DW = 2 * OP_DATA_WIDTH;
    localparam int EW = entry_width(OP_DATA_WIDTH);

    logic [DW-1:0] sel_data;
    logic [1:0]    sel_class;
    logic          sel_carry;
    logic          push;
    logic          pop;
    logic          drop;
    logic [EW-1:0] head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          overflow_q;

    // Fixed priority Arith > Logic > CMP > Shift; losing results are discarded.
    always_comb begin
        sel_data  = '0;
        sel_class = CLS_ARITH;
        sel_carry = 1'b0;
        if (Arith_Flag) begin
            sel_data  = Arith_OUT;
            sel_class = CLS_ARITH;
            sel_carry = Carry_OUT;
        end else if (Logic_Flag) begin
            sel_data  = {{OP_DATA_WIDTH{1'b0}}, Logic_OUT};
            sel_class = CLS_LOGIC;
        end else if (CMP_Flag) begin
            sel_data  = {{(DW-3){1'b0}}, CMP_OUT};
            sel_class = CLS_CMP;
        end else if (Shift_Flag) begin
            sel_data  = {{OP_DATA_WIDTH{1'b0}}, Shift_OUT};
            sel_class = CLS_SHIFT;
        end
    end

    assign push = Arith_Flag || Logic_Flag || CMP_Flag || Shift_Flag;
    assign pop  = !fifo_empty && RES_READY;
    assign drop = push && fifo_full && !pop;

    alu_res_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .srst    (RST),
        .push_i  (push),
        .data_i  ({sel_data, sel_class, sel_carry}),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign RES_DATA  = head[EW-1:3];
    assign RES_CLASS = head[2:1];
    assign RES_CARRY = head[0];
    assign RES_VALID = !fifo_empty;
    assign FIFO_FULL = fifo_full;

    always_ff @(posedge CLK) begin
        if (RST) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

    assign OVERFLOW = overflow_q;

`ifdef ALU_RES_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign DROP_CNT = drop_cnt_q;
`else
    // Without the counter, the sticky OVERFLOW bit is the only drop record.
`endif

endmodule

// File: tb/tb_alu_result_collector.sv
// Scoreboard bench for alu_result_collector: expected entries are queued as
// stimulus is applied and compared as the DUT presents and pops them.
module tb_alu_result_collector;

    localparam int W     = 16;
    localparam int DEPTH = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic [2*W-1:0] Arith_OUT;
    logic          Carry_OUT;
    logic          Arith_Flag;
    logic [W-1:0]  Logic_OUT;
    logic          Logic_Flag;
    logic [2:0]    CMP_OUT;
    logic          CMP_Flag;
    logic [W-1:0]  Shift_OUT;
    logic          Shift_Flag;
    logic [2*W-1:0] RES_DATA;
    logic [1:0]    RES_CLASS;
    logic          RES_CARRY;
    logic          RES_VALID;
    logic          RES_READY;
    logic          FIFO_FULL;
    logic          OVERFLOW;
`ifdef ALU_RES_DROP_CNT_EN
    logic [7:0]    DROP_CNT;
`endif

    typedef struct {
        logic [2*W-1:0] data;
        logic [1:0]     cls;
        logic           carry;
    } ent_t;

    ent_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;
    logic exp_ovf    = 1'b0;
    int   exp_drops  = 0;

    always #5 CLK = ~CLK;

    alu_result_collector #(
        .OP_DATA_WIDTH (W),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Arith_OUT  (Arith_OUT),
        .Carry_OUT  (Carry_OUT),
        .Arith_Flag (Arith_Flag),
        .Logic_OUT  (Logic_OUT),
        .Logic_Flag (Logic_Flag),
        .CMP_OUT    (CMP_OUT),
        .CMP_Flag   (CMP_Flag),
        .Shift_OUT  (Shift_OUT),
        .Shift_Flag (Shift_Flag),
        .RES_DATA   (RES_DATA),
        .RES_CLASS  (RES_CLASS),
        .RES_CARRY  (RES_CARRY),
        .RES_VALID  (RES_VALID),
        .RES_READY  (RES_READY),
        .FIFO_FULL  (FIFO_FULL),
        .OVERFLOW   (OVERFLOW)
`ifdef ALU_RES_DROP_CNT_EN
       ,.DROP_CNT   (DROP_CNT)
`endif
    );

    task automatic idle_inputs();
        Arith_Flag = 0; Logic_Flag = 0; CMP_Flag = 0; Shift_Flag = 0;
        Arith_OUT = '0; Carry_OUT = 0; Logic_OUT = '0; CMP_OUT = '0; Shift_OUT = '0;
    endtask

    // One clock: model the edge, advance, then check every observable output.
    task automatic step();
        ent_t e;
        logic pop_now;
        int   sz;
        pop_now = RES_VALID && RES_READY;
        sz = sb.size();
        if (pop_now) begin
            vectors++;
            if (sz == 0) begin
                miscompares++;
                $display("FAIL pop_on_empty: RES_VALID=1 with model empty");
            end else begin
                if (RES_DATA !== sb[0].data || RES_CLASS !== sb[0].cls || RES_CARRY !== sb[0].carry) begin
                    miscompares++;
                    $display("FAIL popped_entry: got data=%h cls=%b c=%b expected data=%h cls=%b c=%b",
                             RES_DATA, RES_CLASS, RES_CARRY, sb[0].data, sb[0].cls, sb[0].carry);
                end
                void'(sb.pop_front());
            end
        end
        if (!RST && (Arith_Flag || Logic_Flag || CMP_Flag || Shift_Flag)) begin
            e.carry = 1'b0;
            if (Arith_Flag) begin
                e.data = Arith_OUT; e.cls = 2'b00; e.carry = Carry_OUT;
            end else if (Logic_Flag) begin
                e.data = {16'h0, Logic_OUT}; e.cls = 2'b01;
            end else if (CMP_Flag) begin
                e.data = {29'h0, CMP_OUT}; e.cls = 2'b10;
            end else begin
                e.data = {16'h0, Shift_OUT}; e.cls = 2'b11;
            end
            if (sz == DEPTH && !pop_now) begin
                exp_ovf = 1'b1;
                if (exp_drops < 255) exp_drops++;
            end else begin
                sb.push_back(e);
            end
        end
        if (RST) begin
            sb.delete();
            exp_ovf = 1'b0;
            exp_drops = 0;
        end
        @(posedge CLK);
        #1;
        vectors++;
        if (RES_VALID !== (sb.size() != 0) || FIFO_FULL !== (sb.size() == DEPTH) || OVERFLOW !== exp_ovf) begin
            miscompares++;
            $display("FAIL status: got valid=%b full=%b ovf=%b expected valid=%b full=%b ovf=%b",
                     RES_VALID, FIFO_FULL, OVERFLOW, sb.size() != 0, sb.size() == DEPTH, exp_ovf);
        end
        vectors++;
        if (sb.size() != 0) begin
            if (RES_DATA !== sb[0].data || RES_CLASS !== sb[0].cls || RES_CARRY !== sb[0].carry) begin
                miscompares++;
                $display("FAIL head: got data=%h cls=%b c=%b expected data=%h cls=%b c=%b",
                         RES_DATA, RES_CLASS, RES_CARRY, sb[0].data, sb[0].cls, sb[0].carry);
            end
        end else if (RES_DATA !== '0 || RES_CLASS !== 2'b00 || RES_CARRY !== 1'b0) begin
            miscompares++;
            $display("FAIL empty_head: got data=%h cls=%b c=%b expected all zero",
                     RES_DATA, RES_CLASS, RES_CARRY);
        end
`ifdef ALU_RES_DROP_CNT_EN
        vectors++;
        if (DROP_CNT !== 8'(exp_drops)) begin
            miscompares++;
            $display("FAIL drop_cnt: got %0d expected %0d", DROP_CNT, exp_drops);
        end
`endif
        $display("cycle: valid=%b ready=%b data=%h cls=%b c=%b full=%b ovf=%b queued=%0d",
                 RES_VALID, RES_READY, RES_DATA, RES_CLASS, RES_CARRY, FIFO_FULL, OVERFLOW, sb.size());
        idle_inputs();
    endtask

    task automatic drain(input int n);
        RES_READY = 1;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        RST = 1; RES_READY = 0;
        idle_inputs();
        Shift_Flag = 1; Shift_OUT = 16'h1234;
        step();
        step();
        RST = 0;
        vectors++;
        if (RES_VALID !== 0 || FIFO_FULL !== 0 || OVERFLOW !== 0 || RES_DATA !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got valid=%b full=%b ovf=%b data=%h expected zeros",
                     RES_VALID, FIFO_FULL, OVERFLOW, RES_DATA);
        end
    endtask

    task automatic test_single_arith();
        RES_READY = 1;
        Arith_Flag = 1; Arith_OUT = 32'd40; Carry_OUT = 0;
        step();
        vectors++;
        if (RES_VALID !== 1 || RES_DATA !== 32'd40 || RES_CLASS !== 2'b00) begin
            miscompares++;
            $display("FAIL single_arith_latency: got valid=%b data=%h cls=%b expected 1/00000028/00",
                     RES_VALID, RES_DATA, RES_CLASS);
        end
        step();
        vectors++;
        if (RES_VALID !== 0) begin
            miscompares++;
            $display("FAIL single_arith_empty: got valid=%b expected 0", RES_VALID);
        end
    endtask

    task automatic test_logic_cmp();
        RES_READY = 1;
        Logic_Flag = 1; Logic_OUT = 16'hFFF5; Carry_OUT = 1;
        step();
        vectors++;
        if (RES_DATA !== 32'h0000FFF5 || RES_CLASS !== 2'b01 || RES_CARRY !== 0) begin
            miscompares++;
            $display("FAIL logic_entry: got data=%h cls=%b c=%b expected 0000fff5/01/0",
                     RES_DATA, RES_CLASS, RES_CARRY);
        end
        CMP_Flag = 1; CMP_OUT = 3'b010;
        step();
        vectors++;
        if (RES_DATA !== 32'd2 || RES_CLASS !== 2'b10) begin
            miscompares++;
            $display("FAIL cmp_entry: got data=%h cls=%b expected 00000002/10", RES_DATA, RES_CLASS);
        end
        drain(2);
    endtask

    task automatic test_overflow();
        RES_READY = 0;
        for (int i = 1; i <= 6; i++) begin
            Shift_Flag = 1; Shift_OUT = 16'(i);
            step();
        end
        vectors++;
        if (FIFO_FULL !== 1 || OVERFLOW !== 1 || exp_drops != 2) begin
            miscompares++;
            $display("FAIL overflow: got full=%b ovf=%b model_drops=%0d expected 1/1/2",
                     FIFO_FULL, OVERFLOW, exp_drops);
        end
        step();
        vectors++;
        if (RES_DATA !== 32'd1) begin
            miscompares++;
            $display("FAIL hold_stable: got data=%h expected 00000001", RES_DATA);
        end
    endtask

    task automatic test_full_push_pop();
        RES_READY = 1;
        Arith_Flag = 1; Arith_OUT = 32'd300;
        step();
        vectors++;
        if (FIFO_FULL !== 1 || RES_DATA !== 32'd2) begin
            miscompares++;
            $display("FAIL full_push_pop: got full=%b head=%h expected 1/00000002", FIFO_FULL, RES_DATA);
        end
        drain(5);
    endtask

    task automatic test_priority();
        RES_READY = 1;
        Arith_Flag = 1; Arith_OUT = 32'd20; Logic_Flag = 1; Logic_OUT = 16'd10;
        Shift_Flag = 1; Shift_OUT = 16'd7; Carry_OUT = 1;
        step();
        vectors++;
        if (RES_DATA !== 32'd20 || RES_CLASS !== 2'b00 || RES_CARRY !== 1) begin
            miscompares++;
            $display("FAIL priority: got data=%h cls=%b c=%b expected 00000014/00/1",
                     RES_DATA, RES_CLASS, RES_CARRY);
        end
        drain(2);
    endtask

    task automatic test_reset_mid();
        RES_READY = 0;
        for (int i = 0; i < 6; i++) begin
            CMP_Flag = 1; CMP_OUT = 3'(i);
            step();
        end
        RST = 1;
        Logic_Flag = 1; Logic_OUT = 16'hBEEF;
        step();
        RST = 0;
        vectors++;
        if (RES_VALID !== 0 || OVERFLOW !== 0) begin
            miscompares++;
            $display("FAIL reset_mid: got valid=%b ovf=%b expected 0/0", RES_VALID, OVERFLOW);
        end
        Arith_Flag = 1; Arith_OUT = 32'hCAFE0077;
        step();
        vectors++;
        if (RES_VALID !== 1 || RES_DATA !== 32'hCAFE0077) begin
            miscompares++;
            $display("FAIL reset_mid_push: got valid=%b data=%h expected 1/cafe0077", RES_VALID, RES_DATA);
        end
        drain(2);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            Arith_Flag = ($urandom_range(0, 3) == 0);
            Logic_Flag = ($urandom_range(0, 3) == 0);
            CMP_Flag   = ($urandom_range(0, 3) == 0);
            Shift_Flag = ($urandom_range(0, 2) == 0);
            Arith_OUT  = $urandom();
            Carry_OUT  = 1'($urandom_range(0, 1));
            Logic_OUT  = 16'($urandom());
            CMP_OUT    = 3'($urandom());
            Shift_OUT  = 16'($urandom());
            RES_READY  = (i < 150) ? 1'b1 : ($urandom_range(0, 2) != 0);
            step();
        end
        drain(DEPTH + 2);
    endtask

    initial begin
        idle_inputs();
        RST = 1;
        RES_READY = 0;
        @(posedge CLK);
        #1;
        test_reset();
        test_single_arith();
        test_logic_cmp();
        test_overflow();
        test_full_push_pop();
        test_priority();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
